// File: rtl/sar_nb_pkg.sv
// Shared definitions for the successive-approximation search block:
// FSM state encoding and the width of the step counter.
package sar_nb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bits needed to hold the values 0..w, i.e. ceil(log2(w+1)).
  function automatic int sw_of(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < (w + 1)) r = i + 1;
    end
    return r;
  endfunction

  localparam int N_DEF  = 5;
  localparam int SW_DEF = sw_of(N_DEF);

endpackage

// File: rtl/sar_nb_cmp.sv
// Plain n-bit magnitude comparator; sits beside sar_nb in the parent and
// compares the target (a) against the current probe (b).
module sar_nb_cmp #(
  parameter int n = 5
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/sar_nb.sv
// Successive-approximation search: drives a probe value to an external
// comparator and narrows in on the target one bit per cycle.
//
// Handshake: start is a request sampled only while idle; a search is accepted
// on the edge where start=1 in IDLE. busy marks probe cycles, done is a
// one-cycle completion strobe, and result/steps/err are valid from done until
// the next accepted start.
module sar_nb
  import sar_nb_pkg::*;
#(
  parameter  int n  = 5,
  localparam int SW = sw_of(n),
  localparam int KW = (n > 1) ? $clog2(n) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          eq,
  input  logic          lt,
  input  logic          gt,
  output logic [n-1:0]  guess,
  output logic [n-1:0]  result,
  output logic [SW-1:0] steps,
  output logic          busy,
  output logic          done,
  output logic          err,
  output state_t        dbg_state
);

  localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n-1:0] MSB = ONE << (n - 1);

  state_t        state_q, state_d;
  logic [n-1:0]  guess_q, guess_d;
  logic [n-1:0]  acc_q, acc_d;
  logic [KW-1:0] k_q, k_d;
  logic [n-1:0]  result_q, result_d;
  logic [SW-1:0] steps_q, steps_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    acc_d    = acc_q;
    k_d      = k_q;
    result_d = result_q;
    steps_d  = steps_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        guess_d = '0;
        if (start) begin
          state_d  = S_PROBE;
          guess_d  = MSB;
          acc_d    = '0;
          k_d      = KW'(n - 1);
          steps_d  = '0;
          err_d    = 1'b0;
          result_d = '0;
        end
      end
      S_PROBE: begin
        steps_d = steps_q + SW'(1);
        // acc holds the confirmed upper bits; guess is acc plus the trial bit k.
        case ({eq, lt, gt})
          3'b100: begin
            result_d = guess_q;
            guess_d  = '0;
            state_d  = S_DONE;
          end
          3'b001: begin
            if (k_q != '0) begin
              acc_d   = guess_q;
              k_d     = k_q - KW'(1);
              guess_d = guess_q | (ONE << (k_q - KW'(1)));
            end else begin
              err_d    = 1'b1;
              result_d = '0;
              guess_d  = '0;
              state_d  = S_DONE;
            end
          end
          3'b010: begin
            if (k_q != '0) begin
              k_d     = k_q - KW'(1);
              guess_d = acc_q | (ONE << (k_q - KW'(1)));
            end else begin
              result_d = acc_q;
              guess_d  = '0;
              state_d  = S_DONE;
            end
          end
          default: begin
            err_d    = 1'b1;
            result_d = '0;
            guess_d  = '0;
            state_d  = S_DONE;
          end
        endcase
      end
      S_DONE: begin
        guess_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        guess_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign guess     = guess_q;
  assign result    = result_q;
  assign steps     = steps_q;
  assign err       = err_q;
  assign busy      = (state_q == S_PROBE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
